// File: rtl/fnd_scan_if.sv
// Segment-vector input and scanned display outputs of the FND scan driver.
// The master side supplies digit patterns; the slave side drives the display pins.
interface fnd_scan_if;
    logic [41:0] i_six_digit_seg;
    logic [5:0]  i_dp;
    logic [7:0]  o_seg;
    logic [5:0]  o_seg_enb;
    logic        o_frame_tick;

    modport master (
        output i_six_digit_seg,
        output i_dp,
        input  o_seg,
        input  o_seg_enb,
        input  o_frame_tick
    );

    modport slave (
        input  i_six_digit_seg,
        input  i_dp,
        output o_seg,
        output o_seg_enb,
        output o_frame_tick
    );
endinterface

// File: rtl/fnd_scan.sv
// Time-multiplexed 6-digit 7-segment scan driver with per-slot blanking and per-frame input capture.
// Outputs are registered one cycle behind the slot counter; free-running, with no backpressure.
module fnd_scan #(
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 16
) (
    input  logic        clk,
    input  logic        rst,
    fnd_scan_if.slave   bus
);
    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    dig_q, dig_d;
    logic [41:0]   shadow_q, shadow_d;
    logic [5:0]    shadow_dp_q, shadow_dp_d;
    logic          load_pend_q, load_pend_d;
    logic [7:0]    seg_q, seg_d;
    logic [5:0]    seg_enb_q, seg_enb_d;
    logic          frame_tick_q, frame_tick_d;

    logic          cnt_last;
    logic          capture;
    logic          blank;
    logic [6:0]    dig_pat;
    logic          dig_dp;

    generate
        if (BLANK_CYC > 0) begin : g_blank
            localparam logic [CW-1:0] BLANK_W = CW'(BLANK_CYC);
            assign blank = (cnt_q < BLANK_W);
        end else begin : g_no_blank
            assign blank = 1'b0;
        end
    endgenerate

    // Segment pattern and decimal point of the digit currently being strobed.
    always_comb begin
        dig_pat = 7'd0;
        dig_dp  = 1'b0;
        case (dig_q)
            3'd0: begin dig_pat = shadow_q[41:35]; dig_dp = shadow_dp_q[5]; end
            3'd1: begin dig_pat = shadow_q[34:28]; dig_dp = shadow_dp_q[4]; end
            3'd2: begin dig_pat = shadow_q[27:21]; dig_dp = shadow_dp_q[3]; end
            3'd3: begin dig_pat = shadow_q[20:14]; dig_dp = shadow_dp_q[2]; end
            3'd4: begin dig_pat = shadow_q[13:7];  dig_dp = shadow_dp_q[1]; end
            3'd5: begin dig_pat = shadow_q[6:0];   dig_dp = shadow_dp_q[0]; end
            default: begin dig_pat = 7'd0; dig_dp = 1'b0; end
        endcase
    end

    always_comb begin
        cnt_last = (cnt_q == CNT_LAST);
        capture  = load_pend_q || (cnt_last && (dig_q == 3'd5));

        cnt_d = cnt_last ? '0 : cnt_q + CW'(1);
        dig_d = dig_q;
        if (cnt_last) begin
            dig_d = (dig_q == 3'd5) ? 3'd0 : dig_q + 3'd1;
        end

        shadow_d     = shadow_q;
        shadow_dp_d  = shadow_dp_q;
        load_pend_d  = load_pend_q;
        frame_tick_d = capture;
        if (capture) begin
            shadow_d    = bus.i_six_digit_seg;
            shadow_dp_d = bus.i_dp;
            load_pend_d = 1'b0;
        end

        // Enable and segments come from the same registers, so they always switch together.
        if (blank) begin
            seg_enb_d = 6'd0;
            seg_d     = 8'd0;
        end else begin
            seg_enb_d = 6'b100000 >> dig_q;
            seg_d     = {dig_pat, dig_dp};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= '0;
            dig_q        <= 3'd0;
            shadow_q     <= 42'd0;
            shadow_dp_q  <= 6'd0;
            load_pend_q  <= 1'b1;
            seg_q        <= 8'd0;
            seg_enb_q    <= 6'd0;
            frame_tick_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            dig_q        <= dig_d;
            shadow_q     <= shadow_d;
            shadow_dp_q  <= shadow_dp_d;
            load_pend_q  <= load_pend_d;
            seg_q        <= seg_d;
            seg_enb_q    <= seg_enb_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign bus.o_seg        = seg_q;
    assign bus.o_seg_enb    = seg_enb_q;
    assign bus.o_frame_tick = frame_tick_q;
endmodule
